dsp_mac_pipe: RTL
=================

Name: dsp_mac_pipe

Overview:
Parametrised, pipelined multiply(-accumulate) block, successor to the single-shot 16x16 DSP test wrapper. Takes packed operands {B,A} on a valid/ready stream and produces the product on a valid/ready stream. Has configurable operand widths, signedness, pipeline depth, full backpressure, and an optional running accumulator. Maps onto MULT18X18D/ALU54B-class DSP slices; also used as a DSP regression DUT.

Parameters:
A_WIDTH, 16, width of operand A (1..18)
B_WIDTH, 16, width of operand B (1..18)
SIGNED, 0, 1 = two's-complement A and B; 0 = unsigned
STAGES, 3, register stages from input to dout (1..4)
OUT_WIDTH, 40, dout width; must be >= A_WIDTH+B_WIDTH

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
din_valid  in  1  input beat valid
din_ready  out  1  block accepts input this cycle
din  in  A_WIDTH+B_WIDTH  {B, A}; A in the LSBs
acc_clear  in  1  sideband qualified by din_valid; restarts the accumulator with this beat (ignored without DSP_MAC_ACC_EN)
dout_valid  out  1  output beat valid
dout_ready  in  1  downstream accepts output
dout  out  OUT_WIDTH  result

Behaviour:
- Reset (reset=0, async): all stage valid bits 0, dout_valid=0, dout=0, accumulator=0. din_ready=1 once reset is released. Data registers other than dout need not be reset.
- Global advance enable: adv = !dout_valid || dout_ready. din_ready = adv (combinational, no dependence on din_valid).
- Input accept when din_valid && din_ready. Each stage holds {valid, data}. When adv=1, every stage shifts one place. When adv=0, all stages hold. No bubble collapsing.
- Latency: a beat accepted at edge N appears on dout with dout_valid=1 after edge N+STAGES-1, with no stalls. Throughput: 1 beat/cycle while dout_ready=1.
- Multiply at stage 1, result P_WIDTH=A_WIDTH+B_WIDTH. SIGNED=1: operands sign-extended, product sign-extended to OUT_WIDTH. SIGNED=0: zero-extended. Remaining stages are pure delay registers.
- STAGES=1: input register and output register are the same stage. Multiply is combinational into it.
- Output holds stable while dout_valid && !dout_ready (AXI-style). Beats are never dropped or duplicated.
- Simultaneous stall and input: if dout_valid && !dout_ready, din_ready=0 in the same cycle and no beat is taken.
- Reset mid-stream flushes all in-flight beats. No partial output appears after reset release.
- Wrap-around: product arithmetic is exact (no overflow possible in P_WIDTH). Accumulator behaviour is given below.

Optional Feature:
Macro DSP_MAC_ACC_EN.
- Defined: acc_clear travels with its beat. When a beat moves into the output stage:
  - if its acc_clear=1: acc = ext(product)
  - otherwise: acc = acc + ext(product), modulo 2^OUT_WIDTH (silent wrap, no saturation)
  - dout = new acc value.
- The accumulator updates only on beats that advance into the output stage, never on held cycles. The first beat after reset accumulates onto 0.
- Not defined: acc_clear is ignored, no accumulator register is built, and dout = ext(product).

Decomposition:
- Package dsp_mac_pkg: MAX_OPERAND_WIDTH=18, MAX_STAGES=4, function ext_product(product, signed, OUT_WIDTH), and the stage payload typedef {valid, acc_clear, data}.
- Sub-module dsp_pipe_stage: one enable-gated register stage with valid bit, instantiated STAGES-1 times via generate.
- Top holds the multiplier, the advance logic and the optional accumulator.

Test Plan:
1. Defaults, unsigned: din={16'd300,16'd200}, dout_ready=1 -> 3 cycles later dout=60000, dout_valid=1 for exactly one cycle.
2. SIGNED=1: A=16'hFFFF (-1), B=16'd5 -> dout=40'hFF_FFFF_FFFB. Max case: A=B=16'h8000 -> dout=40'h00_4000_0000.
3. Backpressure: stream 8 beats (A=i, B=i+1). Hold dout_ready=0 for 5 cycles mid-stream -> din_ready low during the stall, dout stable, all 8 products i*(i+1) delivered in order, none lost or duplicated.
4. STAGES=1 and STAGES=4 builds: back-to-back 16 random beats -> latency 0 / 3 edges respectively, full throughput, results match a reference model.
5. Async reset: assert reset=0 mid-cycle with 2 beats in flight -> dout_valid=0 and dout=0 immediately. After release, no stale beat emerges.
6. DSP_MAC_ACC_EN: beats (3x4, clear=1), (5x6), (2x2) -> dout 12, 42, 46. Next beat (1x1, clear=1) -> dout 1. Accumulator wrap check: acc=2^40-1 plus 1x1 -> dout 0.

Source files
------------

// File: rtl/dsp_mac_pkg.sv
// rtl/dsp_mac_pkg.sv - shared limits, stage payload type and product extension for dsp_mac_pipe
// Contents:
//   MAX_OPERAND_WIDTH, MAX_STAGES   legal ranges of the operand width and pipeline depth
//   MAX_P_WIDTH, MAX_OUT_WIDTH      widest raw product carried in a stage / widest supported dout
//   stage_t                         {valid, acc_clear, data} payload of one pipeline stage
//   ext_product()                   sign- or zero-extends a raw product to the output width
package dsp_mac_pkg;

    localparam int MAX_OPERAND_WIDTH = 18;
    localparam int MAX_STAGES        = 4;
    localparam int MAX_P_WIDTH       = 2 * MAX_OPERAND_WIDTH;
    localparam int MAX_OUT_WIDTH     = 64;

    // Stages carry the raw product; extension to dout width happens at the output stage.
    typedef struct packed {
        logic                   valid;
        logic                   acc_clear;
        logic [MAX_P_WIDTH-1:0] data;
    } stage_t;

    // Only the low p_width bits of product are meaningful; bits at or above out_width are zeroed
    // so the caller can size-cast the result without losing information.
    function automatic logic [MAX_OUT_WIDTH-1:0] ext_product(
        input logic [MAX_P_WIDTH-1:0] product,
        input int                     p_width,
        input bit                     is_signed,
        input int                     out_width
    );
        logic [MAX_OUT_WIDTH-1:0] wide;
        logic [MAX_OUT_WIDTH-1:0] p_mask;
        logic [MAX_OUT_WIDTH-1:0] o_mask;
        logic                     sign;
        wide   = MAX_OUT_WIDTH'(product);
        p_mask = (MAX_OUT_WIDTH'(1) << p_width) - MAX_OUT_WIDTH'(1);
        o_mask = (out_width >= MAX_OUT_WIDTH) ? '1
                                              : ((MAX_OUT_WIDTH'(1) << out_width) - MAX_OUT_WIDTH'(1));
        sign   = is_signed && (((product >> (p_width - 1)) & MAX_P_WIDTH'(1)) != '0);
        return (sign ? (wide | ~p_mask) : (wide & p_mask)) & o_mask;
    endfunction

endpackage

// File: rtl/dsp_mac_pipe_if.sv
// rtl/dsp_mac_pipe_if.sv - operand/result stream bundle for dsp_mac_pipe
// Signals:
//   din_valid, din_ready, din {B,A}, acc_clear   operand stream (acc_clear qualified by din_valid)
//   dout_valid, dout_ready, dout                 result stream
// Modports: master = producer/consumer around the block, slave = the block itself.
interface dsp_mac_pipe_if #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = 40
);

    logic                         din_valid;
    logic                         din_ready;
    logic [A_WIDTH+B_WIDTH-1:0]   din;
    logic                         acc_clear;
    logic                         dout_valid;
    logic                         dout_ready;
    logic [OUT_WIDTH-1:0]         dout;

    modport master (
        output din_valid, din, acc_clear, dout_ready,
        input  din_ready, dout_valid, dout
    );

    modport slave (
        input  din_valid, din, acc_clear, dout_ready,
        output din_ready, dout_valid, dout
    );

endinterface

// File: rtl/dsp_pipe_stage.sv
// rtl/dsp_pipe_stage.sv - one enable-gated pipeline register with valid bit
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset (clears valid only)
//   en     global advance; stage loads d when high, holds when low
//   d      incoming stage payload
//   q      registered stage payload
module dsp_pipe_stage
    import dsp_mac_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   en,
    input  stage_t d,
    output stage_t q
);

    logic                   valid_q;
    logic                   clear_q;
    logic [MAX_P_WIDTH-1:0] data_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else if (en) begin
            valid_q <= d.valid;
        end
    end

    // Payload is meaningless without valid, so it is neither reset nor loaded on bubbles.
    always_ff @(posedge clock) begin
        if (en && d.valid) begin
            clear_q <= d.acc_clear;
            data_q  <= d.data;
        end
    end

    assign q = '{valid: valid_q, acc_clear: clear_q, data: data_q};

endmodule

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - pipelined multiply(-accumulate) with valid/ready streams
// Parameters: A_WIDTH, B_WIDTH (1..18), SIGNED (0/1), STAGES (1..4), OUT_WIDTH (>= A_WIDTH+B_WIDTH, <= 64)
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    dsp_mac_pipe_if.slave: din_valid/din_ready/din/acc_clear in, dout_valid/dout_ready/dout out
// Optional macro DSP_MAC_ACC_EN: dout becomes a running accumulator of products, restarted by acc_clear.
module dsp_mac_pipe
    import dsp_mac_pkg::*;
#(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int SIGNED    = 0,
    parameter int STAGES    = 3,
    parameter int OUT_WIDTH = 40
) (
    input  logic           clock,
    input  logic           reset,
    dsp_mac_pipe_if.slave  bus
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic [A_WIDTH-1:0]   op_a;
    logic [B_WIDTH-1:0]   op_b;
    logic [P_WIDTH-1:0]   a_ext;
    logic [P_WIDTH-1:0]   b_ext;
    logic [P_WIDTH-1:0]   product;
    logic                 adv;
    logic                 out_valid_q;
    logic [OUT_WIDTH-1:0] dout_q;
    logic [OUT_WIDTH-1:0] ext_val;
    logic [OUT_WIDTH-1:0] next_dout;

    // chain[0] is the beat entering stage 1; chain[i] is the output of stage i.
    stage_t chain [0:STAGES-1];

    assign op_a = bus.din[A_WIDTH-1:0];
    assign op_b = bus.din[P_WIDTH-1:A_WIDTH];

    // Extending both operands to P_WIDTH first makes one unsigned multiplier serve both modes:
    // the low P_WIDTH bits of a two's-complement product are the exact signed result.
    assign a_ext   = {{B_WIDTH{(SIGNED != 0) && op_a[A_WIDTH-1]}}, op_a};
    assign b_ext   = {{A_WIDTH{(SIGNED != 0) && op_b[B_WIDTH-1]}}, op_b};
    assign product = a_ext * b_ext;

    // Whole pipe moves together; a held output freezes every stage behind it.
    assign adv = !out_valid_q || bus.dout_ready;

    assign chain[0] = '{valid: bus.din_valid, acc_clear: bus.acc_clear, data: MAX_P_WIDTH'(product)};

    for (genvar i = 0; i < STAGES - 1; i++) begin : g_stage
        dsp_pipe_stage u_stage (
            .clock (clock),
            .reset (reset),
            .en    (adv),
            .d     (chain[i]),
            .q     (chain[i+1])
        );
    end

    assign ext_val = OUT_WIDTH'(ext_product(chain[STAGES-1].data, P_WIDTH, SIGNED != 0, OUT_WIDTH));

`ifdef DSP_MAC_ACC_EN
    // dout_q only changes on valid beats, so it doubles as the accumulator register.
    assign next_dout = chain[STAGES-1].acc_clear ? ext_val : dout_q + ext_val;
`else
    logic acc_clear_unused;
    assign acc_clear_unused = chain[STAGES-1].acc_clear;
    assign next_dout        = ext_val;
`endif

    // Output stage: the last register of the pipe, reset to zero so dout is clean after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
        end else if (adv) begin
            out_valid_q <= chain[STAGES-1].valid;
            if (chain[STAGES-1].valid) begin
                dout_q <= next_dout;
            end
        end
    end

    assign bus.din_ready  = adv;
    assign bus.dout_valid = out_valid_q;
    assign bus.dout       = dout_q;

endmodule
